// File: rtl/dff_pipe.sv
// dff_pipe -- parameterised register pipeline with a live tap select and an
// enabled-cycle counter.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   advance enable (0 = stall, all state holds)
//   clr      in   synchronous clear, wins over en
//   d        in   [WIDTH-1:0] input sample
//   d_vld    in   input sample valid
//   dly_sel  in   [SEL_W-1:0] tap select, latency = dly_sel+1 enabled edges
//   q        out  [WIDTH-1:0] data at selected tap
//   q_vld    out  valid at selected tap
//   cnt      out  [CNT_W-1:0] enabled-cycle count
//   cnt_ovf  out  sticky: increment attempted while cnt was all-ones
module dff_pipe #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 32,
   parameter int CNT_WRAP = 1,
   localparam int SEL_W   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic             d_vld,
   input  logic [SEL_W-1:0] dly_sel,
   output logic [WIDTH-1:0] q,
   output logic             q_vld,
   output logic [CNT_W-1:0] cnt,
   output logic             cnt_ovf
);

   logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
   logic [DEPTH-1:0]            vld_q,  vld_d;
   logic [CNT_W-1:0]            cnt_q,  cnt_d;
   logic                        ovf_q,  ovf_d;
   logic [SEL_W-1:0]            tap;

   // Stage and counter next-state. Data shifts regardless of valid; the
   // valid bit alone qualifies it downstream.
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      if (clr) begin
         data_d = '0;
         vld_d  = '0;
         cnt_d  = '0;
         ovf_d  = 1'b0;
      end else if (en) begin
         data_d[0] = d;
         vld_d[0]  = d_vld;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
            vld_d[i]  = vld_q[i-1];
         end
         if (cnt_q == '1) begin
            ovf_d = 1'b1;
            cnt_d = (CNT_WRAP != 0) ? '0 : cnt_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         vld_q  <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   // Out-of-range selects clamp to the last stage.
   always_comb begin
      tap = (dly_sel >= SEL_W'(DEPTH)) ? SEL_W'(DEPTH - 1) : dly_sel;
   end

   // Compare-based mux keeps the index width independent of DEPTH.
   always_comb begin
      q     = '0;
      q_vld = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tap == SEL_W'(i)) begin
            q     = data_q[i];
            q_vld = vld_q[i];
         end
      end
   end

   assign cnt     = cnt_q;
   assign cnt_ovf = ovf_q;

endmodule

// File: tb/tb_dff_pipe.sv
module tb_dff_pipe;

   localparam int W = 8;
   localparam int N = 4;
   localparam int S = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic         clr;
   logic [W-1:0] d;
   logic         d_vld;
   logic [S-1:0] dly_sel;

   logic [W-1:0] q_m,   q_w,   q_s;
   logic         qv_m,  qv_w,  qv_s;
   logic [31:0]  cnt_m;
   logic [3:0]   cnt_w, cnt_s;
   logic         ovf_m, ovf_w, ovf_s;

   int vectors     = 0;
   int miscompares = 0;

   // reference state: newest-first history of accepted {vld,data}, and the
   // number of enabled edges since the last clear/reset
   logic [W:0] hist[$];
   longint     n_en;

   always #5 clk = ~clk;

   dff_pipe #(.WIDTH(W), .DEPTH(N)) u_main (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
      .dly_sel(dly_sel), .q(q_m), .q_vld(qv_m), .cnt(cnt_m), .cnt_ovf(ovf_m));

   dff_pipe #(.WIDTH(W), .DEPTH(N), .CNT_W(4), .CNT_WRAP(1)) u_wrap (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
      .dly_sel(dly_sel), .q(q_w), .q_vld(qv_w), .cnt(cnt_w), .cnt_ovf(ovf_w));

   dff_pipe #(.WIDTH(W), .DEPTH(N), .CNT_W(4), .CNT_WRAP(0)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
      .dly_sel(dly_sel), .q(q_s), .q_vld(qv_s), .cnt(cnt_s), .cnt_ovf(ovf_s));

   task automatic model_clear();
      hist.delete();
      for (int i = 0; i < N; i++) hist.push_back('0);
      n_en = 0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      int         k;
      logic [W:0] e;
      k = (int'(dly_sel) >= N) ? N - 1 : int'(dly_sel);
      e = hist[k];
      chk("main_q",     64'(q_m),  64'(e[W-1:0]));
      chk("main_q_vld", 64'(qv_m), 64'(e[W]));
      chk("main_cnt",   64'(cnt_m), 64'(n_en & 64'hFFFF_FFFF));
      chk("main_ovf",   64'(ovf_m), 64'(n_en >= 64'h1_0000_0000));
      chk("wrap_q",     64'(q_w),  64'(e[W-1:0]));
      chk("sat_q_vld",  64'(qv_s), 64'(e[W]));
      chk("wrap_cnt",   64'(cnt_w), 64'(n_en % 16));
      chk("wrap_ovf",   64'(ovf_w), 64'(n_en >= 16));
      chk("sat_cnt",    64'(cnt_s), 64'((n_en >= 15) ? 15 : n_en));
      chk("sat_ovf",    64'(ovf_s), 64'(n_en >= 16));
   endtask

   // apply inputs, take one edge, update the model, check 1ns after the edge
   task automatic step(input logic e_i, input logic c_i, input logic v_i,
                       input logic [W-1:0] d_i, input logic [S-1:0] s_i);
      en = e_i; clr = c_i; d_vld = v_i; d = d_i; dly_sel = s_i;
      @(posedge clk);
      if (c_i) begin
         model_clear();
      end else if (e_i) begin
         hist.push_front({v_i, d_i});
         void'(hist.pop_back());
         n_en++;
      end
      #1;
      check_all();
   endtask

   task automatic resel(input logic [S-1:0] s_i);
      dly_sel = s_i;
      #1;
      check_all();
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      check_all();
      chk("rst_q_zero", 64'(q_m), 64'd0);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; d = '0; d_vld = 1'b0; dly_sel = '0;
      model_clear();
      #2;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // first edge after reset is a normal edge
      step(1, 0, 0, 8'h00, 0);
      chk("cnt_after_first_edge", 64'(cnt_m), 64'd1);

      // latency sweep with dly_sel=2
      step(1, 1, 0, 8'h00, 2);
      step(1, 0, 1, 8'hA5, 2);
      step(1, 0, 0, 8'h11, 2);
      step(1, 0, 0, 8'h22, 2);
      chk("lat3_q", 64'(q_m), 64'hA5);
      chk("lat3_q_vld", 64'(qv_m), 64'd1);
      step(1, 0, 0, 8'h33, 2);
      chk("lat3_vld_drop", 64'(qv_m), 64'd0);

      // stall: inject, one more enabled edge, 5 stalls, then advance
      step(1, 1, 0, 8'h00, 3);
      step(1, 0, 1, 8'h3C, 3);
      step(1, 0, 0, 8'h00, 3);
      for (int i = 0; i < 5; i++) step(0, 0, 1'($urandom), 8'($urandom), 3);
      step(1, 0, 0, 8'h00, 3);
      step(1, 0, 0, 8'h00, 3);
      chk("stall_q", 64'(q_m), 64'h3C);
      chk("stall_q_vld", 64'(qv_m), 64'd1);
      chk("stall_cnt", 64'(cnt_m), 64'd4);

      // clamp and live reselect
      step(1, 1, 0, 8'h00, 7);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 8'(8'h50 + i), 7);
      chk("clamp_q", 64'(q_m), 64'h50);
      resel(3);
      resel(0);
      chk("resel_q", 64'(q_m), 64'h53);
      resel(5);

      // counter: 16 enabled edges from clear, then clear
      step(1, 1, 0, 8'h00, 0);
      for (int i = 0; i < 16; i++) step(1, 0, 1'($urandom), 8'($urandom), 3'($urandom));
      chk("wrap16_cnt", 64'(cnt_w), 64'd0);
      chk("sat16_cnt", 64'(cnt_s), 64'd15);
      chk("sat16_ovf", 64'(ovf_s), 64'd1);
      step(0, 1, 0, 8'h00, 0);
      chk("clr_ovf", 64'(ovf_s), 64'd0);

      // clr beats en
      for (int i = 0; i < 4; i++) step(1, 0, 1, 8'($urandom), 3);
      step(1, 1, 1, 8'hFF, 3);
      chk("clr_en_q_vld", 64'(qv_m), 64'd0);
      chk("clr_en_cnt", 64'(cnt_m), 64'd0);

      // async reset with a full pipeline
      for (int i = 0; i < 4; i++) step(1, 0, 1, 8'($urandom), 1);
      async_reset();
      step(1, 0, 0, 8'h00, 1);
      step(1, 0, 0, 8'h00, 3);

      // randomized traffic with occasional clears and resets
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(3, 0) != 0), ($urandom_range(24, 0) == 0),
              1'($urandom), 8'($urandom), 3'($urandom));
         if ($urandom_range(9, 0) == 0) resel(3'($urandom));
         if ($urandom_range(59, 0) == 0) async_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: data width per stage in bits, legal range 1..64.
REQ-002 SHALL provide parameter DEPTH, default 4: number of pipeline stages, legal range 1..16.
REQ-003 SHALL provide parameter CNT_W, default 32: cycle-counter width in bits, legal range 2..32.
REQ-004 SHALL provide parameter CNT_WRAP, default 1: 1 = counter wraps to 0 at all-ones; 0 = counter saturates at all-ones.
REQ-005 SHALL derive localparam SEL_W = $clog2(DEPTH)+1 for the tap-select width.
REQ-006 SHALL provide port clk  input  1  rising-edge clock.
REQ-007 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL provide port en  input  1  advance enable; 0 = stall, so all state holds.
REQ-009 SHALL provide port clr  input  1  synchronous clear.
REQ-010 SHALL provide port d  input  WIDTH  input data sample.
REQ-011 SHALL provide port d_vld  input  1  input data is valid.
REQ-012 SHALL provide port dly_sel  input  SEL_W  tap select; latency = dly_sel+1 enabled cycles.
REQ-013 SHALL provide port q  output  WIDTH  data at the selected tap.
REQ-014 SHALL provide port q_vld  output  1  valid flag at the selected tap.
REQ-015 SHALL provide port cnt  output  CNT_W  count of enabled cycles.
REQ-016 SHALL provide port cnt_ovf  output  1  sticky flag: an increment was attempted while cnt was all-ones.

Function
REQ-017 SHALL hold DEPTH registered stages, each holding a WIDTH-bit data field and a 1-bit valid field.
REQ-018 On a rising clk edge with en=1 and clr=0, stage[0] SHALL load {d, d_vld} and each stage[i] SHALL load stage[i-1] for i=1..DEPTH-1.
REQ-019 With en=0 and clr=0, every stage, cnt and cnt_ovf SHALL hold their values, whatever d, d_vld or dly_sel are doing.
REQ-020 The data field of a stage SHALL load even when its incoming valid is 0; only the valid field qualifies the data.
REQ-021 q and q_vld SHALL be a combinational mux of stage[k], with k = min(dly_sel, DEPTH-1); dly_sel values of DEPTH or more clamp to the last stage.
REQ-022 A sample presented with en=1 at edge N SHALL appear on q at edge N+dly_sel, provided en=1 on every intervening edge; stalls extend the latency cycle-for-cycle.
REQ-023 A change to dly_sel SHALL take effect on q and q_vld in the same cycle, with no pipeline flush.
REQ-024 clr=1 at a rising edge SHALL zero every stage's data and valid, set cnt to 0 and clear cnt_ovf.
REQ-025 clr SHALL take priority over en; with clr=1 the d input is discarded.
REQ-026 cnt SHALL increment by 1 on each edge with en=1 and clr=0.
REQ-027 When cnt is all-ones at an increment edge and CNT_WRAP=1, cnt SHALL become 0.
REQ-028 When cnt is all-ones at an increment edge and CNT_WRAP=0, cnt SHALL stay at all-ones.
REQ-029 cnt_ovf SHALL set at the same edge as REQ-027 or REQ-028 fires, in both modes.
REQ-030 cnt_ovf SHALL remain set until clr or reset.
REQ-031 All state elements SHALL be flops on clk; there SHALL be no latches and no combinational path from en or clr to any output.

Reset
REQ-032 While rst_n=0, asynchronously: every stage data and valid = 0, cnt = 0, cnt_ovf = 0.
REQ-033 As a consequence of REQ-032 and REQ-021, q = 0 and q_vld = 0 while rst_n=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight samples; after deassertion, q_vld SHALL stay 0 until a new valid sample has traversed the selected latency.
REQ-035 The first rising edge after rst_n deasserts SHALL behave as a normal edge: with en=1, cnt = 1 after that edge.

Verification
REQ-036 Latency sweep (WIDTH=8, DEPTH=4): dly_sel=2, en=1, d=0xA5 with d_vld=1 for one cycle -> q=0xA5, q_vld=1 exactly 3 edges after input, then q_vld=0 next cycle.
REQ-037 Stall: dly_sel=3, d=0x3C injected, en=0 for 5 cycles after the 2nd edge -> q=0x3C appears 4 enabled edges after injection (9 edges total); cnt advanced by only 4.
REQ-038 Clamp and live reselect: dly_sel=7 with DEPTH=4 -> same latency as dly_sel=3; switch dly_sel 3->0 mid-stream -> q shows stage[0] in the same cycle.
REQ-039 Counter wrap (CNT_W=4, CNT_WRAP=1): 16 enabled cycles from reset -> cnt=0, cnt_ovf=1. Same with CNT_WRAP=0 -> cnt=15, cnt_ovf=1, then clr -> cnt=0, cnt_ovf=0.
REQ-040 clr vs en and async reset: clr=1 with en=1, d_vld=1 -> all q_vld=0 and cnt=0 next cycle. Pulse rst_n low between edges while pipeline full -> q=0, q_vld=0 immediately, without waiting for a clk edge.
